mips_rf_wb_arbiter: RTL

Shares the single write port of the MIPS register file among `NREQ` writeback sources, such as the ALU writeback, the load unit and the multiply/divide unit. Each cycle it grants at most one requester, using round-robin priority. It drives registered `wen`/`WA`/`WD` into the register file and suppresses writes to register 0. It sits between the writeback sources and the register file write port.

---
 rtl/mips_rf_wb_arbiter_pkg.sv | 17 +
 rtl/mips_rf_wb_arbiter_rr_pick.sv | 49 ++++
 rtl/mips_rf_wb_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/mips_rf_wb_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | MIPS_Generic_Definitions                                           |
// | Shared register-file types and constants for the MIPS datapath.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package MIPS_Generic_Definitions;

    localparam int Data_Width = 32;

    typedef logic [4:0] rfa_t;

    // Writes to this register are architecturally discarded.
    localparam rfa_t RF_ZERO_ADDR = 5'd0;

endpackage : MIPS_Generic_Definitions
`default_nettype wire

// File: rtl/mips_rf_wb_arbiter_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_rr_pick                                                       |
// | Combinational round-robin picker: rotate, fixed-priority, unrotate.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mips_rr_pick #(
    parameter int N  = 3,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    localparam logic [PW:0] c_N = (PW+1)'(N);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic           w_found;
    logic [PW-1:0]  w_rot_idx;
    logic [PW:0]    w_sum;

    always_comb begin
        w_dbl     = {req, req};
        // Bit k of w_rot is requester (ptr+k) mod N.
        w_rot     = w_dbl[ptr +: N];
        w_found   = 1'b0;
        w_rot_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found   = 1'b1;
                w_rot_idx = PW'(k);
            end
        end
        w_sum = {1'b0, w_rot_idx} + {1'b0, ptr};
        if (w_sum >= c_N) begin
            w_sum = w_sum - c_N;
        end
        idx = w_sum[PW-1:0];
        gnt = '0;
        for (int k = 0; k < N; k++) begin
            gnt[k] = w_found && (idx == PW'(k));
        end
    end

endmodule : mips_rr_pick
`default_nettype wire

// File: rtl/mips_rf_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_rf_wb_arbiter                                                 |
// | Round-robin share of the register-file write port, r0 filtered.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mips_rf_wb_arbiter
    import MIPS_Generic_Definitions::*;
#(
    parameter int NREQ = 3,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NREQ-1:0]                     req_valid,
    output logic [NREQ-1:0]                     req_ready,
    input  rfa_t [NREQ-1:0]                     req_addr,
    input  logic [NREQ-1:0][Data_Width-1:0]     req_data,
    input  logic                                hold,
    output logic                                rf_wen,
    output rfa_t                                rf_wa,
    output logic [Data_Width-1:0]               rf_wd,
    output logic [PW-1:0]                       grant_id,
    output logic                                drop_r0
);

    localparam logic [PW-1:0] c_LAST = PW'(NREQ - 1);

    logic [PW-1:0]         r_ptr;
    logic [PW-1:0]         r_grant_id;
    logic                  r_wen;
    rfa_t                  r_wa;
    logic [Data_Width-1:0] r_wd;
    logic                  r_drop;

    logic [NREQ-1:0]       w_req;
    logic [NREQ-1:0]       w_gnt;
    logic [PW-1:0]         w_idx;
    logic                  w_hs;
    rfa_t                  w_addr;
    logic [Data_Width-1:0] w_data;

    assign w_req = req_valid & {NREQ{~hold}};

    mips_rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_pick (
        .req (w_req),
        .ptr (r_ptr),
        .gnt (w_gnt),
        .idx (w_idx)
    );

    // Grants are masked while reset is asserted, even though it is asynchronous.
    assign req_ready = w_gnt & {NREQ{rst_n}};
    assign w_hs      = |req_ready;
    assign w_addr    = req_addr[w_idx];
    assign w_data    = req_data[w_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_grant_id <= '0;
            r_wen      <= 1'b0;
            r_wa       <= RF_ZERO_ADDR;
            r_wd       <= '0;
            r_drop     <= 1'b0;
        end else if (w_hs) begin
            r_ptr      <= (w_idx == c_LAST) ? '0 : w_idx + 1'b1;
            r_grant_id <= w_idx;
            if (w_addr == RF_ZERO_ADDR) begin
                r_wen  <= 1'b0;
                r_drop <= 1'b1;
            end else begin
                r_wen  <= 1'b1;
                r_wa   <= w_addr;
                r_wd   <= w_data;
                r_drop <= 1'b0;
            end
        end else begin
            r_wen  <= 1'b0;
            r_drop <= 1'b0;
        end
    end

    assign rf_wen   = r_wen;
    assign rf_wa    = r_wa;
    assign rf_wd    = r_wd;
    assign grant_id = r_grant_id;
    assign drop_r0  = r_drop;

endmodule : mips_rf_wb_arbiter
`default_nettype wire
